hilo_md_sched: RTL

//  Scheduler for the E-stage HI/LO multiply/divide datapath.
//  - Accepts mult/multu/div/divu from the E stage and issues a one-cycle start to the datapath.
//  - Times the operation with a down-counter and pulses the HI/LO commit on the final cycle.
//  - Generates the D-stage stall for any HI/LO-touching instruction while the unit is occupied.

---
 rtl/hilo_md_sched.sv | 92 +++++++++
 1 files changed

// File: rtl/hilo_md_sched.sv
// HI/LO multiply/divide scheduler: issues start, times the op, pulses commit.
// Stalls D-stage HI/LO users while the unit is occupied.
module hilo_md_sched #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] md_op_E,
    input  logic       flush_E,
    input  logic       md_abort,
    input  logic       md_use_D,
    output logic       md_start,
    output logic [2:0] md_op_q,
    output logic       md_busy,
    output logic       md_commit,
    output logic       stall_D,
    output logic       err_overlap
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] MUL_N = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       md_op_d;
    logic             err_q, err_d;
    logic             op_valid;
    logic             last_cyc;

    assign op_valid    = (md_op_E <= 3'b011) & ~flush_E;
    assign last_cyc    = (cnt_q == ONE);
    assign md_busy     = (state_q == RUN);
    assign md_start    = (state_q == IDLE) & op_valid & ~md_abort;
    assign md_commit   = md_busy & last_cyc & ~md_abort;
    assign stall_D     = md_use_D & (md_busy | md_start);
    assign err_overlap = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        md_op_d = md_op_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (md_start) begin
                    md_op_d = md_op_E;
                    cnt_d   = md_op_E[1] ? DIV_N : MUL_N;
                    state_d = RUN;
                end
            end
            RUN: begin
                // overlapping op is dropped; only flagged for checkers
                if (op_valid) begin
                    err_d = 1'b1;
                end
                if (md_abort || last_cyc) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            md_op_q <= 3'b000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            md_op_q <= md_op_d;
            err_q   <= err_d;
        end
    end

endmodule
